// File: rtl/speck_pkg.sv
// speck_pkg
// Shared definitions for the iterative SPECK encryption core:
//   - state_t      : controller states (IDLE, RUN, DONE)
//   - rol / ror    : width-parametrised rotations on a 64-bit carrier
//   - default_alpha / default_beta : rotation constants chosen by word width
package speck_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Rotation constants: the 16-bit variant uses 7/2, wider words use 8/3.
    localparam int ALPHA_NARROW = 7;
    localparam int BETA_NARROW  = 2;
    localparam int ALPHA_WIDE   = 8;
    localparam int BETA_WIDE    = 3;

    // Widest word the rotation helpers can carry.
    localparam int ROT_W_MAX = 64;

    function automatic int default_alpha(input int w);
        return (w > 16) ? ALPHA_WIDE : ALPHA_NARROW;
    endfunction

    function automatic int default_beta(input int w);
        return (w > 16) ? BETA_WIDE : BETA_NARROW;
    endfunction

    // All-ones in the low w bits.
    function automatic logic [ROT_W_MAX-1:0] width_mask(input int w);
        return {ROT_W_MAX{1'b1}} >> (ROT_W_MAX - w);
    endfunction

    // Rotate the low w bits of v left by amt; bits above w come back as zero.
    function automatic logic [ROT_W_MAX-1:0] rol(input logic [ROT_W_MAX-1:0] v,
                                                 input int amt, input int w);
        logic [ROT_W_MAX-1:0] vm;
        int                   sh;
        vm = v & width_mask(w);
        sh = amt % w;
        if (sh == 0) begin
            return vm;
        end
        return ((vm << sh) | (vm >> (w - sh))) & width_mask(w);
    endfunction

    // Right rotation expressed as the complementary left rotation.
    function automatic logic [ROT_W_MAX-1:0] ror(input logic [ROT_W_MAX-1:0] v,
                                                 input int amt, input int w);
        return rol(v, w - (amt % w), w);
    endfunction

endpackage

// File: rtl/speck_iter_core_round.sv
// speck_round
// Combinational SPECK round R(a, b, c):
//   a_next = (ROR(a, ALPHA) + b) ^ c
//   b_next = ROL(b, BETA) ^ a_next
// Used both for the data path (x, y, k_i) and the key schedule (l_i, k_i, i).
// Ports:
//   a, b, c  : round inputs, WORD_W bits each
//   a_next   : new a word
//   b_next   : new b word
module speck_round
    import speck_pkg::*;
#(
    parameter int WORD_W = 16,
    parameter int ALPHA  = 7,
    parameter int BETA   = 2
) (
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic [WORD_W-1:0] c,
    output logic [WORD_W-1:0] a_next,
    output logic [WORD_W-1:0] b_next
);

    logic [WORD_W-1:0] a_ror;
    logic [WORD_W-1:0] b_rol;

    assign a_ror  = WORD_W'(ror(ROT_W_MAX'(a), ALPHA, WORD_W));
    assign b_rol  = WORD_W'(rol(ROT_W_MAX'(b), BETA, WORD_W));

    // Addition wraps mod 2^WORD_W by virtue of the result width.
    assign a_next = (a_ror + b) ^ c;
    assign b_next = b_rol ^ a_next;

endmodule

// File: rtl/speck_iter_core.sv
// speck_iter_core
// Iterative SPECK encryption: one round per clock with the key schedule
// expanded on the fly alongside the data path.
// Ports:
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  : input handshake; in_ready is high only while idle
//   in_block             : plaintext, x = upper word, y = lower word
//   in_key               : key, lowest word = k0, then l0, l1, ...
//   out_valid / out_ready: output handshake; out_block held while waiting
//   out_block            : ciphertext, same packing as in_block
//   dbg_key              : round key register (key used by the current round)
module speck_iter_core
    import speck_pkg::*;
#(
    parameter int WORD_W    = 16,
    parameter int KEY_WORDS = 4,
    parameter int ROUNDS    = 22,
    parameter int ALPHA     = default_alpha(WORD_W),
    parameter int BETA      = default_beta(WORD_W)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [2*WORD_W-1:0]         in_block,
    input  logic [KEY_WORDS*WORD_W-1:0] in_key,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [2*WORD_W-1:0]         out_block,
    output logic [WORD_W-1:0]           dbg_key
);

    localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam int LW = KEY_WORDS - 1;   // depth of the l shift register
    localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

    state_t state_reg, state_next;

    logic [WORD_W-1:0]          x_reg, y_reg, k_reg;
    logic [LW-1:0][WORD_W-1:0]  l_reg, l_next;   // index 0 is the head
    logic [RW-1:0]              round_reg;

    logic [WORD_W-1:0] x_rnd, y_rnd, l_rnd, k_rnd, round_word;
    logic              accept, advance, last_round;

    assign accept     = (state_reg == IDLE) && in_valid;
    assign advance    = (state_reg == RUN);
    assign last_round = (round_reg == LAST_ROUND);
    assign round_word = WORD_W'(round_reg);

    speck_round #(.WORD_W(WORD_W), .ALPHA(ALPHA), .BETA(BETA)) u_data_round (
        .a      (x_reg),
        .b      (y_reg),
        .c      (k_reg),
        .a_next (x_rnd),
        .b_next (y_rnd)
    );

    speck_round #(.WORD_W(WORD_W), .ALPHA(ALPHA), .BETA(BETA)) u_key_round (
        .a      (l_reg[0]),
        .b      (k_reg),
        .c      (round_word),
        .a_next (l_rnd),
        .b_next (k_rnd)
    );

    // Controller: outputs depend on state only, so neither handshake input
    // has a combinational path to any output.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                if (last_round) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // l shift register: load from the key on accept, otherwise pop the head
    // and push the freshly expanded word at the tail each round.
    for (genvar gi = 0; gi < LW; gi++) begin : g_l
        logic [WORD_W-1:0] shift_in;
        if (gi == LW - 1) begin : g_tail
            assign shift_in = l_rnd;
        end else begin : g_body
            assign shift_in = l_reg[gi+1];
        end
        assign l_next[gi] = accept  ? in_key[(gi+1)*WORD_W +: WORD_W] :
                            advance ? shift_in : l_reg[gi];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_reg <= '0;
        end else begin
            l_reg <= l_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg     <= '0;
            y_reg     <= '0;
            k_reg     <= '0;
            round_reg <= '0;
        end else if (accept) begin
            x_reg     <= in_block[2*WORD_W-1:WORD_W];
            y_reg     <= in_block[WORD_W-1:0];
            k_reg     <= in_key[WORD_W-1:0];
            round_reg <= '0;
        end else if (advance) begin
            x_reg     <= x_rnd;
            y_reg     <= y_rnd;
            k_reg     <= k_rnd;
            round_reg <= round_reg + 1'b1;
        end
    end

    assign out_block = {x_reg, y_reg};
    assign dbg_key   = k_reg;

endmodule
